// File: rtl/instr_exec_sequencer.sv
// Walks a batch of entries in the 32-entry instruction register, executes each one
// and hands every result to a downstream sink over a valid/ready handshake.
// instruction_word layout: [67:64] opcode, [63:32] op_a, [31:0] op_b (two's complement).
// Opcodes: 0 ZERO, 1 PASSA, 2 PASSB, 3 ADD, 4 SUB, 5 MULT, 6 DIV, 7 MOD, 8..15 illegal.
module instr_exec_sequencer #(
    parameter int DIV_LATENCY = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [4:0]         start_addr,
    input  logic [5:0]         count,
    output logic [4:0]         read_pointer,
    input  logic [67:0]        instruction_word,
    output logic               busy,
    output logic               done,
    output logic               res_valid,
    input  logic               res_ready,
    output logic signed [63:0] res_data,
    output logic [4:0]         res_addr,
    output logic               res_err,
    output logic [5:0]         exec_count,
    output logic [2:0]         state_dbg
);

    // Handshake: a result transfers on the rising edge where res_valid && res_ready.
    // While res_valid=1 and res_ready=0, res_data/res_addr/res_err are held stable.

    localparam logic [3:0] OP_ZERO  = 4'd0;
    localparam logic [3:0] OP_PASSA = 4'd1;
    localparam logic [3:0] OP_PASSB = 4'd2;
    localparam logic [3:0] OP_ADD   = 4'd3;
    localparam logic [3:0] OP_SUB   = 4'd4;
    localparam logic [3:0] OP_MULT  = 4'd5;
    localparam logic [3:0] OP_DIV   = 4'd6;
    localparam logic [3:0] OP_MOD   = 4'd7;

    localparam logic [3:0] DIV_LAST = 4'(DIV_LATENCY - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_EXEC   = 3'd2,
        S_OUTPUT = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    state_t state, state_next;

    logic [67:0]        instr;
    logic [5:0]         remaining;
    logic [3:0]         div_cnt;
    logic [3:0]         op;
    logic signed [63:0] op_a, op_b;
    logic signed [63:0] alu_data;
    logic               alu_err;
    logic               is_div;
    logic               exec_done;

    assign op        = instr[67:64];
    assign op_a      = {{32{instr[63]}}, instr[63:32]};
    assign op_b      = {{32{instr[31]}}, instr[31:0]};
    assign is_div    = (op == OP_DIV) || (op == OP_MOD);
    assign exec_done = !is_div || (div_cnt == DIV_LAST);

    assign busy      = (state != S_IDLE);
    assign done      = (state == S_DONE);
    assign state_dbg = state;

    // Operands are widened to 64 bits first, so -2^31 / -1 is representable.
    always_comb begin
        alu_data = '0;
        alu_err  = 1'b0;
        case (op)
            OP_ZERO:  alu_data = '0;
            OP_PASSA: alu_data = op_a;
            OP_PASSB: alu_data = op_b;
            OP_ADD:   alu_data = op_a + op_b;
            OP_SUB:   alu_data = op_a - op_b;
            OP_MULT:  alu_data = op_a * op_b;
            OP_DIV: begin
                if (op_b == 64'sd0) alu_err  = 1'b1;
                else                alu_data = op_a / op_b;
            end
            OP_MOD: begin
                if (op_b == 64'sd0) alu_err  = 1'b1;
                else                alu_data = op_a % op_b;
            end
            default:  alu_err = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:   if (start) state_next = (count == 6'd0) ? S_DONE : S_FETCH;
            S_FETCH:  state_next = S_EXEC;
            S_EXEC:   if (exec_done) state_next = S_OUTPUT;
            S_OUTPUT: if (res_ready) state_next = (remaining == 6'd1) ? S_DONE : S_FETCH;
            S_DONE:   state_next = S_IDLE;
            default:  state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            read_pointer <= '0;
            remaining    <= '0;
            exec_count   <= '0;
            instr        <= '0;
            div_cnt      <= '0;
            res_valid    <= 1'b0;
            res_data     <= '0;
            res_addr     <= '0;
            res_err      <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        read_pointer <= start_addr;
                        remaining    <= (count > 6'd32) ? 6'd32 : count;
                        exec_count   <= '0;
                    end
                end
                S_FETCH: begin
                    instr   <= instruction_word;
                    div_cnt <= '0;
                end
                S_EXEC: begin
                    if (exec_done) begin
                        res_data  <= alu_data;
                        res_err   <= alu_err;
                        res_addr  <= read_pointer;
                        res_valid <= 1'b1;
                    end else begin
                        div_cnt <= div_cnt + 4'd1;
                    end
                end
                S_OUTPUT: begin
                    if (res_ready) begin
                        res_valid  <= 1'b0;
                        exec_count <= exec_count + 6'd1;
                        remaining  <= remaining - 6'd1;
                        // 5-bit pointer wraps 31 -> 0 on its own.
                        if (remaining != 6'd1) read_pointer <= read_pointer + 5'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_exec_sequencer.sv
// Randomized bench for instr_exec_sequencer: batches are predicted from the instruction
// memory contents with plain 64-bit arithmetic and compared result by result.
module tb_instr_exec_sequencer;

    localparam int DIV_LAT = 4;

    localparam logic [3:0] OP_ZERO  = 4'd0;
    localparam logic [3:0] OP_PASSA = 4'd1;
    localparam logic [3:0] OP_PASSB = 4'd2;
    localparam logic [3:0] OP_ADD   = 4'd3;
    localparam logic [3:0] OP_SUB   = 4'd4;
    localparam logic [3:0] OP_MULT  = 4'd5;
    localparam logic [3:0] OP_DIV   = 4'd6;
    localparam logic [3:0] OP_MOD   = 4'd7;

    logic               clk = 1'b0;
    logic               reset;
    logic               start;
    logic [4:0]         start_addr;
    logic [5:0]         count;
    logic [4:0]         read_pointer;
    logic [67:0]        instruction_word;
    logic               busy;
    logic               done;
    logic               res_valid;
    logic               res_ready;
    logic signed [63:0] res_data;
    logic [4:0]         res_addr;
    logic               res_err;
    logic [5:0]         exec_count;
    logic [2:0]         state_dbg;

    logic [67:0] mem [32];

    int n_checks = 0;
    int n_fail   = 0;

    instr_exec_sequencer #(.DIV_LATENCY(DIV_LAT)) dut (
        .clk              (clk),
        .reset            (reset),
        .start            (start),
        .start_addr       (start_addr),
        .count            (count),
        .read_pointer     (read_pointer),
        .instruction_word (instruction_word),
        .busy             (busy),
        .done             (done),
        .res_valid        (res_valid),
        .res_ready        (res_ready),
        .res_data         (res_data),
        .res_addr         (res_addr),
        .res_err          (res_err),
        .exec_count       (exec_count),
        .state_dbg        (state_dbg)
    );

    assign instruction_word = mem[read_pointer];

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    // ---------------- checking ----------------
    task automatic check(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic void model(input logic [67:0] w, output longint d, output logic e);
        longint a, b;
        a = longint'($signed(w[63:32]));
        b = longint'($signed(w[31:0]));
        d = 0;
        e = 1'b0;
        case (w[67:64])
            OP_ZERO:  d = 0;
            OP_PASSA: d = a;
            OP_PASSB: d = b;
            OP_ADD:   d = a + b;
            OP_SUB:   d = a - b;
            OP_MULT:  d = a * b;
            OP_DIV:   if (b == 0) e = 1'b1; else d = a / b;
            OP_MOD:   if (b == 0) e = 1'b1; else d = a % b;
            default:  e = 1'b1;
        endcase
    endfunction

    // ---------------- driver tasks ----------------
    task automatic put(input int idx, input logic [3:0] op, input int a, input int b);
        mem[idx] = {op, a[31:0], b[31:0]};
    endtask

    task automatic fill_random();
        for (int i = 0; i < 32; i++) begin
            int a, b;
            a = $urandom;
            b = $urandom;
            if ($urandom_range(3) == 0) a = $urandom_range(20) - 10;
            if ($urandom_range(3) == 0) b = $urandom_range(6) - 3;
            if ($urandom_range(9) == 0) a = 32'h8000_0000;
            put(i, 4'($urandom_range(15)), a, b);
        end
    endtask

    // Runs one batch; every cycle is sampled on the falling edge.
    task automatic run_batch(input logic [4:0] sa, input int cnt, input int pct);
        logic [63:0] exp_q [$];
        logic [4:0]  addr_q [$];
        logic        err_q [$];
        int          lat_q [$];
        int          n, t, ref_t;
        logic        seen, stalled, fin;
        longint      held_d;
        logic [4:0]  held_a;
        logic        held_e;

        n = (cnt > 32) ? 32 : cnt;
        for (int i = 0; i < n; i++) begin
            logic [4:0] ad;
            longint     d;
            logic       e;
            ad = sa + 5'(i);
            model(mem[ad], d, e);
            exp_q.push_back(d);
            addr_q.push_back(ad);
            err_q.push_back(e);
            lat_q.push_back((mem[ad][67:64] == OP_DIV || mem[ad][67:64] == OP_MOD) ? DIV_LAT + 2 : 3);
        end

        @(negedge clk);
        start      = 1'b1;
        start_addr = sa;
        count      = cnt[5:0];
        t = 0; ref_t = 0; seen = 0; stalled = 0; fin = 0;
        held_d = 0; held_a = '0; held_e = 1'b0;

        while (!fin && t < 3000) begin
            @(negedge clk);
            t++;
            start = 1'b0;
            if (t == 1) check("busy_after_start", busy, 1);
            if (res_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_valid", 1, 0);
                end else begin
                    if (!seen) begin
                        check("latency", t - ref_t, lat_q[0]);
                        seen = 1;
                    end
                    if (stalled) begin
                        check("stall_data", res_data, held_d);
                        check("stall_addr", res_addr, held_a);
                        check("stall_err", res_err, held_e);
                    end
                end
                res_ready = ($urandom_range(99) < pct);
                if (res_ready) begin
                    if (exp_q.size() != 0) begin
                        check("res_data", res_data, exp_q.pop_front());
                        check("res_addr", res_addr, addr_q.pop_front());
                        check("res_err", res_err, err_q.pop_front());
                        void'(lat_q.pop_front());
                    end
                    ref_t = t; seen = 0; stalled = 0;
                end else begin
                    stalled = 1;
                    held_d = res_data; held_a = res_addr; held_e = res_err;
                    if ($urandom_range(1) == 1) begin
                        start      = 1'b1;
                        start_addr = 5'($urandom);
                        count      = 6'($urandom_range(1, 63));
                    end
                end
            end else begin
                res_ready = ($urandom_range(99) < pct);
            end
            if (done) begin
                check("done_time", t, ref_t + 1);
                check("exec_count", exec_count, n);
                check("results_left", exp_q.size(), 0);
                fin = 1;
            end
        end
        if (!fin) check("batch_timeout", 0, 1);
        @(negedge clk);
        check("done_one_cycle", done, 0);
        check("idle_after_done", busy, 0);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_rp"}, read_pointer, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_valid"}, res_valid, 0);
        check({tag, "_data"}, res_data, 0);
        check({tag, "_addr"}, res_addr, 0);
        check({tag, "_err"}, res_err, 0);
        check({tag, "_count"}, exec_count, 0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        reset = 1'b1; start = 1'b0; start_addr = '0; count = '0; res_ready = 1'b0;
        for (int i = 0; i < 32; i++) mem[i] = '0;
        repeat (3) @(negedge clk);
        check_reset_values("por");
        reset = 1'b0;

        put(3, OP_ADD, 5, -7);
        run_batch(5'd3, 1, 100);

        put(30, OP_MULT, 100000, -300000);
        put(31, OP_SUB, 32'h8000_0000, 1);
        put(0, OP_PASSB, 0, 9);
        run_batch(5'd30, 3, 100);

        put(5, OP_DIV, -7, 2);
        put(6, OP_MOD, -7, 2);
        put(7, OP_DIV, 32'h8000_0000, -1);
        run_batch(5'd5, 3, 100);

        put(8, OP_DIV, 10, 0);
        put(9, 4'hC, 1, 2);
        put(10, OP_ZERO, 5, 5);
        run_batch(5'd8, 3, 100);

        run_batch(5'd3, 3, 15);
        run_batch(5'd0, 0, 100);
        fill_random();
        run_batch(5'd7, 40, 70);

        // Reset while a DIV is in EXEC, then a clean batch from a new address.
        put(12, OP_DIV, 100, 7);
        put(13, OP_ADD, 1, 2);
        put(14, OP_MOD, 100, 7);
        put(15, OP_PASSA, 4, 0);
        @(negedge clk);
        start = 1'b1; start_addr = 5'd12; count = 6'd4;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check_reset_values("mid_reset");
        run_batch(5'd13, 3, 100);

        repeat (15) begin
            fill_random();
            run_batch(5'($urandom), $urandom_range(0, 40), $urandom_range(20, 100));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/instr_exec_sequencer.md
Name: instr_exec_sequencer

Overview:
- Sequences execution of a block of instructions held in the 32-entry instruction register.
- On a start command it drives read_pointer over consecutive entries and captures each instruction_t.
- For each instruction it computes the result, including multi-cycle DIV/MOD, and presents the result on a valid/ready handshake to the downstream result sink.
- It sits between the testbench/host control and the instruction register read port.

Parameters:
DIV_LATENCY, 4, EXEC-state cycles for DIV/MOD (legal 1..16); all other opcodes take 1 EXEC cycle.

Ports:
clk  input  1  clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
start  input  1  single-cycle command; accepted only in IDLE
start_addr  input  address_t (5)  first instruction register entry to execute
count  input  6  number of instructions; 0 = empty batch; 33..63 clamped to 32
read_pointer  output  address_t (5)  read address to the instruction register
instruction_word  input  instruction_t  entry at read_pointer (combinational read)
busy  output  1  high in every state except IDLE
done  output  1  one-cycle pulse when the batch completes
res_valid  output  1  result available
res_ready  input  1  sink accepts result
res_data  output  64 signed  result value
res_addr  output  address_t (5)  entry the result belongs to
res_err  output  1  result flagged: divide-by-zero or illegal opcode
exec_count  output  6  results accepted in the current/last batch

Behaviour:
- Reset (synchronous, any state, mid-batch included): state=IDLE; read_pointer=0, busy=0, done=0, res_valid=0, res_data=0, res_addr=0, res_err=0, exec_count=0. An in-flight result is discarded.
- States: IDLE, FETCH, EXEC, OUTPUT, DONE.
- IDLE: on start=1:
  - load read_pointer=start_addr, remaining=min(count,32), exec_count=0.
  - Go to FETCH, or to DONE if count=0.
  - start in any other state is ignored.
- FETCH (1 cycle): register instruction_word into the internal instr; go to EXEC.
- EXEC:
  - non-DIV/MOD opcodes: result computed in 1 cycle; on exit res_data/res_err/res_addr=read_pointer are registered, res_valid=1, go to OUTPUT.
  - DIV/MOD: a counter holds EXEC for exactly DIV_LATENCY cycles, then registers the result identically.
- OUTPUT: outputs are held stable while res_valid=1 and res_ready=0. On the handshake edge (res_valid & res_ready):
  - res_valid=0, exec_count+1, remaining-1.
  - If remaining was 1, go to DONE.
  - Otherwise read_pointer+1, wrapping 31 to 0, and go to FETCH.
- DONE: done=1 for exactly one cycle; go to IDLE. busy stays 1 in DONE.
- Latency: with res_ready tied high, a 1-cycle op has res_valid high 3 cycles after the start edge (FETCH, EXEC, OUTPUT), and each further instruction adds 3 cycles. DIV/MOD adds DIV_LATENCY-1 cycles.
- Arithmetic: 64-bit signed, with op_a/op_b sign-extended.
  - ZERO gives 0; PASSA gives op_a; PASSB gives op_b.
  - ADD gives op_a+op_b; SUB gives op_a-op_b.
  - MULT gives the full 64-bit product.
  - DIV truncates toward zero. MOD takes the sign of the dividend.
  - -2^31 DIV -1 = +2147483648, with no error.
- Errors:
  - DIV/MOD with op_b=0: res_data=0, res_err=1, latency still DIV_LATENCY.
  - Opcodes 8..15: res_data=0, res_err=1, 1-cycle EXEC.
  - res_err=0 for all other results.
- The instruction register contents are sampled only in FETCH; writes to other entries during a batch have no effect on the current instruction.

Test Plan:
1. Reset, then load entry 3 = {ADD, 5, -7}. Issue start, start_addr=3, count=1, res_ready=1. Expect res_valid 3 cycles after the start edge, res_data=-2, res_addr=3, res_err=0, done the cycle after the handshake, exec_count=1.
2. Load entries 30, 31, 0 = {MULT, 100000, -300000}, {SUB, -2^31, 1}, {PASSB, 0, 9}. Run count=3 from 30. Expect results -30000000000, -2147483649, 9 in that order, with res_addr 30, 31, 0 (wrap).
3. Use DIV_LATENCY=4. Run {DIV, -7, 2} then {MOD, -7, 2}. Expect -3 and -1, each with res_valid 6 cycles after its FETCH edge. Run {DIV, -2^31, -1} and expect 2147483648 with res_err=0.
4. Run {DIV, 10, 0} and an entry with opcode 4'hC. Expect res_data=0 and res_err=1 for both. Run {ZERO, 5, 5} and expect 0 with res_err=0.
5. Backpressure: hold res_ready=0 for 5 cycles. Expect res_valid/res_data/res_addr stable. Pulse start during the stall and expect it ignored. Expect count=0 to give done 1 cycle after start with no res_valid, and count=40 to produce exactly 32 results.
6. Assert reset during the EXEC of a DIV in a 4-instruction batch. Expect all outputs at their reset values the next cycle and state IDLE. A new start must then execute normally from its start_addr.
